// File: rtl/rename_pkg.sv
// Shared sizes and types for the rename stage (map tables, renamed uop record).
// Optional busy table is enabled with the RENAME_BUSY_TABLE_EN macro.
package rename_pkg;

  localparam int PHYS_REGS = 64;
  localparam int ARCH_REGS = 32;
  localparam int PHYS_W    = $clog2(PHYS_REGS);
  localparam int ARCH_W    = $clog2(ARCH_REGS);

  typedef logic [PHYS_W-1:0] preg_t;
  typedef logic [ARCH_W-1:0] areg_t;

  typedef struct packed {
    preg_t prs1;
    preg_t prs2;
    preg_t prd;
    preg_t old_prd;
    logic  rd_wr;
  } renamed_uop_t;

endpackage

// File: rtl/rename_stage_map_table.sv
// Speculative and committed register alias tables: 3 spec reads, 1 spec write,
// 1 commit write, and a flush that restores spec from commit (commit forwarded).
module map_table
  import rename_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  areg_t i_rd_addr [3],
  output preg_t o_rd_data [3],
  input  logic  i_spec_we,
  input  areg_t i_spec_waddr,
  input  preg_t i_spec_wdata,
  input  logic  i_commit_we,
  input  areg_t i_commit_waddr,
  input  preg_t i_commit_wdata,
  input  logic  i_flush
);

  preg_t r_spec   [ARCH_REGS];
  preg_t r_commit [ARCH_REGS];
  preg_t w_commit_next [ARCH_REGS];
  logic  w_commit_hit;

  assign w_commit_hit = i_commit_we && (i_commit_waddr != '0);

  // NOTE: every variable driven here gets a value on every path, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < ARCH_REGS; i++) begin
      w_commit_next[i] = r_commit[i];
    end
    if (w_commit_hit) begin
      w_commit_next[i_commit_waddr] = i_commit_wdata;
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      o_rd_data[k] = (i_rd_addr[k] == '0) ? '0 : r_spec[i_rd_addr[k]];
    end
  end

  // NOTE: the tables are flop arrays that must come up as the identity map,
  // so unlike a RAM they are reset, using non-blocking assignments throughout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_spec[i]   <= preg_t'(i);
        r_commit[i] <= preg_t'(i);
      end
    end else begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        r_commit[i] <= w_commit_next[i];
      end
      if (i_flush) begin
        for (int i = 0; i < ARCH_REGS; i++) begin
          r_spec[i] <= w_commit_next[i];
        end
      end else if (i_spec_we && (i_spec_waddr != '0)) begin
        r_spec[i_spec_waddr] <= i_spec_wdata;
      end
    end
  end

endmodule

// File: rtl/rename_stage.sv
// Single-wide rename stage: RAT lookup, free-list pop, one registered output slot.
// Define RENAME_BUSY_TABLE_EN to add the physical-register busy table and source-ready outputs.
module rename_stage
  import rename_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  output logic  in_ready,
  input  areg_t in_rs1,
  input  areg_t in_rs2,
  input  areg_t in_rd,
  input  logic  in_rd_wr,
  output logic  fl_alloc_valid,
  input  logic  fl_alloc_ready,
  input  preg_t fl_alloc_pd,
  output logic  out_valid,
  input  logic  out_ready,
  output preg_t out_prs1,
  output preg_t out_prs2,
  output preg_t out_prd,
  output preg_t out_old_prd,
  output logic  out_rd_wr,
`ifdef RENAME_BUSY_TABLE_EN
  input  logic  wb_valid,
  input  preg_t wb_prd,
  output logic  out_prs1_rdy,
  output logic  out_prs2_rdy,
`endif
  input  logic  commit_valid,
  input  areg_t commit_rd,
  input  preg_t commit_prd,
  input  logic  flush_valid
);

  logic         r_out_valid;
  renamed_uop_t r_out;
  renamed_uop_t w_next;
  logic         w_need_alloc;
  logic         w_in_ready;
  logic         w_accept;
  logic         w_alloc;
  areg_t        w_rd_addr [3];
  preg_t        w_rd_data [3];

  assign w_need_alloc = in_rd_wr && (in_rd != '0);
  assign w_in_ready   = !flush_valid && (!r_out_valid || out_ready)
                        && (!w_need_alloc || fl_alloc_ready);
  assign w_accept     = in_valid && w_in_ready;
  assign w_alloc      = w_accept && w_need_alloc;

  assign w_rd_addr[0] = in_rs1;
  assign w_rd_addr[1] = in_rs2;
  assign w_rd_addr[2] = in_rd;

  // Sources read the table before this cycle's rd write lands, so rs==rd sees the old mapping.
  map_table u_map_table (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_rd_addr      (w_rd_addr),
    .o_rd_data      (w_rd_data),
    .i_spec_we      (w_alloc),
    .i_spec_waddr   (in_rd),
    .i_spec_wdata   (fl_alloc_pd),
    .i_commit_we    (commit_valid),
    .i_commit_waddr (commit_rd),
    .i_commit_wdata (commit_prd),
    .i_flush        (flush_valid)
  );

  always_comb begin
    w_next.prs1    = w_rd_data[0];
    w_next.prs2    = w_rd_data[1];
    w_next.prd     = w_need_alloc ? fl_alloc_pd : '0;
    w_next.old_prd = w_need_alloc ? w_rd_data[2] : '0;
    w_next.rd_wr   = w_need_alloc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out       <= '0;
    end else if (flush_valid) begin
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out       <= w_next;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign in_ready       = w_in_ready;
  assign fl_alloc_valid = w_alloc;
  assign out_valid      = r_out_valid;
  assign out_prs1       = r_out.prs1;
  assign out_prs2       = r_out.prs2;
  assign out_prd        = r_out.prd;
  assign out_old_prd    = r_out.old_prd;
  assign out_rd_wr      = r_out.rd_wr;

`ifdef RENAME_BUSY_TABLE_EN
  logic [PHYS_REGS-1:0] r_busy;
  logic                 r_out_prs1_rdy;
  logic                 r_out_prs2_rdy;
  logic                 w_prs1_rdy;
  logic                 w_prs2_rdy;

  assign w_prs1_rdy = !r_busy[w_next.prs1] || (wb_valid && (wb_prd == w_next.prs1));
  assign w_prs2_rdy = !r_busy[w_next.prs2] || (wb_valid && (wb_prd == w_next.prs2));

  // The allocation set is written after the writeback clear so that set wins on a tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy         <= '0;
      r_out_prs1_rdy <= 1'b0;
      r_out_prs2_rdy <= 1'b0;
    end else if (flush_valid) begin
      r_busy <= '0;
    end else begin
      if (wb_valid) begin
        r_busy[wb_prd] <= 1'b0;
      end
      if (w_alloc && (fl_alloc_pd != '0)) begin
        r_busy[fl_alloc_pd] <= 1'b1;
      end
      if (w_accept) begin
        r_out_prs1_rdy <= w_prs1_rdy;
        r_out_prs2_rdy <= w_prs2_rdy;
      end
    end
  end

  assign out_prs1_rdy = r_out_prs1_rdy;
  assign out_prs2_rdy = r_out_prs2_rdy;
`endif

endmodule

// File: tb/tb_rename_stage.sv
// Directed bench for rename_stage: per-cycle vector table plus flush/commit/reset sequences.
module tb_rename_stage;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [4:0] in_rs1, in_rs2, in_rd;
  logic       in_rd_wr;
  logic       fl_alloc_valid, fl_alloc_ready;
  logic [5:0] fl_alloc_pd;
  logic       out_valid, out_ready;
  logic [5:0] out_prs1, out_prs2, out_prd, out_old_prd;
  logic       out_rd_wr;
  logic       commit_valid;
  logic [4:0] commit_rd;
  logic [5:0] commit_prd;
  logic       flush_valid;
`ifdef RENAME_BUSY_TABLE_EN
  logic       wb_valid;
  logic [5:0] wb_prd;
  logic       out_prs1_rdy, out_prs2_rdy;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rename_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_rs1         (in_rs1),
    .in_rs2         (in_rs2),
    .in_rd          (in_rd),
    .in_rd_wr       (in_rd_wr),
    .fl_alloc_valid (fl_alloc_valid),
    .fl_alloc_ready (fl_alloc_ready),
    .fl_alloc_pd    (fl_alloc_pd),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_prs1       (out_prs1),
    .out_prs2       (out_prs2),
    .out_prd        (out_prd),
    .out_old_prd    (out_old_prd),
    .out_rd_wr      (out_rd_wr),
`ifdef RENAME_BUSY_TABLE_EN
    .wb_valid       (wb_valid),
    .wb_prd         (wb_prd),
    .out_prs1_rdy   (out_prs1_rdy),
    .out_prs2_rdy   (out_prs2_rdy),
`endif
    .commit_valid   (commit_valid),
    .commit_rd      (commit_rd),
    .commit_prd     (commit_prd),
    .flush_valid    (flush_valid)
  );

  typedef struct {
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       wr, flr;
    logic [5:0] pd;
    logic       ordy;
    logic       e_ir, e_al, e_ov;
    logic [5:0] e_p1, e_p2, e_pd, e_old;
    logic       e_wr;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic wr, input logic [5:0] pd);
    in_valid    = v;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_rd       = rd;
    in_rd_wr    = wr;
    fl_alloc_pd = pd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0);
    fl_alloc_ready = 1'b1;
    out_ready      = 1'b1;
    commit_valid   = 1'b0;
    commit_rd      = '0;
    commit_prd     = '0;
    flush_valid    = 1'b0;
`ifdef RENAME_BUSY_TABLE_EN
    wb_valid = 1'b0;
    wb_prd   = '0;
`endif

    //           v rs1 rs2 rd wr flr pd ordy  ir al ov  p1  p2  pd old wr
    vecs[0]  = '{1,  5,  0, 5, 1, 1, 32, 1,   1, 1, 1,  5,  0, 32, 5, 1};
    vecs[1]  = '{1,  5,  0, 7, 1, 1, 33, 1,   1, 1, 1, 32,  0, 33, 7, 1};
    vecs[2]  = '{1,  7,  0, 3, 1, 0,  0, 1,   0, 0, 0, 32,  0, 33, 7, 1};
    vecs[3]  = '{1,  7,  5, 0, 1, 0,  0, 1,   1, 0, 1, 33, 32,  0, 0, 0};
    vecs[4]  = '{1,  3,  7, 3, 0, 0,  0, 1,   1, 0, 1,  3, 33,  0, 0, 0};
    vecs[5]  = '{1,  1,  2, 4, 1, 1, 34, 0,   0, 0, 1,  3, 33,  0, 0, 0};
    vecs[6]  = '{1,  1,  2, 4, 1, 1, 34, 0,   0, 0, 1,  3, 33,  0, 0, 0};
    vecs[7]  = '{1,  1,  2, 4, 1, 1, 34, 0,   0, 0, 1,  3, 33,  0, 0, 0};
    vecs[8]  = '{1,  1,  2, 4, 1, 1, 34, 1,   1, 1, 1,  1,  2, 34, 4, 1};
    vecs[9]  = '{1,  4,  5, 4, 1, 1, 35, 1,   1, 1, 1, 34, 32, 35, 34, 1};
    vecs[10] = '{0,  0,  0, 0, 0, 1,  0, 1,   1, 0, 0, 34, 32, 35, 34, 1};

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_prd", out_prd, 0);
    rst_n = 1'b1;
    #1;
    check("rst_alloc_valid", fl_alloc_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_old_prd", out_old_prd, 0);

`ifdef RENAME_BUSY_TABLE_EN
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 6'd32);
    step();
    drive(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 6'd0);
    step();
    check("busy_prs1", out_prs1, 32);
    check("busy_rdy1_busy", out_prs1_rdy, 0);
    check("busy_rdy2_p0", out_prs2_rdy, 1);
    wb_valid = 1'b1;
    wb_prd   = 6'd32;
    step();
    check("busy_rdy1_bypass", out_prs1_rdy, 1);
    wb_valid = 1'b0;
    step();
    check("busy_rdy1_cleared", out_prs1_rdy, 1);
    drive(1'b1, 5'd0, 5'd0, 5'd6, 1'b1, 6'd33);
    wb_valid = 1'b1;
    wb_prd   = 6'd33;
    step();
    wb_valid = 1'b0;
    drive(1'b1, 5'd6, 5'd0, 5'd0, 1'b0, 6'd0);
    step();
    check("busy_set_wins", out_prs1_rdy, 0);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0);
    step();
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
`endif

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].wr, vecs[i].pd);
      fl_alloc_ready = vecs[i].flr;
      out_ready      = vecs[i].ordy;
      #1;
      check($sformatf("v%0d_in_ready", i), in_ready, vecs[i].e_ir);
      check($sformatf("v%0d_alloc", i), fl_alloc_valid, vecs[i].e_al);
      step();
      check($sformatf("v%0d_out_valid", i), out_valid, vecs[i].e_ov);
      check($sformatf("v%0d_prs1", i), out_prs1, vecs[i].e_p1);
      check($sformatf("v%0d_prs2", i), out_prs2, vecs[i].e_p2);
      check($sformatf("v%0d_prd", i), out_prd, vecs[i].e_pd);
      check($sformatf("v%0d_old_prd", i), out_old_prd, vecs[i].e_old);
      check($sformatf("v%0d_rd_wr", i), out_rd_wr, vecs[i].e_wr);
    end
    fl_alloc_ready = 1'b1;
    out_ready      = 1'b1;

    // Spec map now 5->32, 7->33, 4->35; committed map is still identity.
    commit_valid = 1'b1;
    commit_rd    = 5'd5;
    commit_prd   = 6'd32;
    step();
    commit_valid = 1'b0;
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 6'd40);
    #1;
    check("seq_alloc_40", fl_alloc_valid, 1);
    step();
    check("seq_prd_40", out_prd, 40);
    check("seq_old_32", out_old_prd, 32);

    flush_valid = 1'b1;
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 6'd41);
    #1;
    check("flush_in_ready", in_ready, 0);
    check("flush_no_pop", fl_alloc_valid, 0);
    step();
    check("flush_out_valid", out_valid, 0);
    flush_valid = 1'b0;
    drive(1'b1, 5'd5, 5'd7, 5'd0, 1'b0, 6'd0);
    step();
    check("post_flush_valid", out_valid, 1);
    check("post_flush_prs1", out_prs1, 32);
    check("post_flush_prs2", out_prs2, 7);

    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0);
    flush_valid  = 1'b1;
    commit_valid = 1'b1;
    commit_rd    = 5'd6;
    commit_prd   = 6'd41;
    step();
    check("flush_commit_valid", out_valid, 0);
    flush_valid  = 1'b0;
    commit_valid = 1'b0;
    drive(1'b1, 5'd6, 5'd5, 5'd0, 1'b0, 6'd0);
    step();
    check("fwd_commit_prs1", out_prs1, 41);
    check("fwd_commit_prs2", out_prs2, 32);

    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0);
    commit_valid = 1'b1;
    commit_rd    = 5'd0;
    commit_prd   = 6'd50;
    step();
    commit_valid = 1'b0;
    flush_valid  = 1'b1;
    step();
    flush_valid = 1'b0;
    drive(1'b1, 5'd0, 5'd4, 5'd0, 1'b0, 6'd0);
    step();
    check("r0_prs1", out_prs1, 0);
    check("r4_restored", out_prs2, 4);

    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 6'd44);
    step();
    check("pre_reset_valid", out_valid, 1);
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_prd", out_prd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5'd5, 5'd6, 5'd0, 1'b0, 6'd0);
    step();
    check("rst_rat_prs1", out_prs1, 5);
    check("rst_rat_prs2", out_prs2, 6);

    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 6'd0);
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
